// File: rtl/hsv_pkg.sv
// Shared types for the HSV frame sequencer: controller states, coordinate width
// and the sideband bundle that travels alongside the converter pipeline.
package hsv_pkg;

   localparam int unsigned CoordW = 10;

   typedef enum logic [1:0] {
      StIdle,
      StWaitSof,
      StActive,
      StDrain
   } state_e;

   typedef struct packed {
      logic fv;
      logic dv;
      logic sof;
      logic eol;
      logic eof;
   } sideband_t;

endpackage

// File: rtl/hsv_sideband_delay.sv
// Fixed-depth shift register for sideband markers, used to line them up with
// a pipelined datapath. clr_i wipes every stage in one cycle.
module hsv_sideband_delay
   import hsv_pkg::*;
#(
   parameter int unsigned Depth = 3
) (
   input  logic      clk_i,
   input  logic      clr_i,
   input  sideband_t d_i,
   output sideband_t q_o
);

   sideband_t pipe_q [Depth];

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         for (int i = 0; i < Depth; i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         pipe_q[0] <= d_i;
         for (int i = 1; i < Depth; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   assign q_o = pipe_q[Depth-1];

endmodule

// File: rtl/hsv_frame_ctrl.sv
// Frame sequencer for the RGB565-to-HSV converter: tracks frame position, gates the
// converter, emits latency-matched markers and checks each frame's geometry.
module hsv_frame_ctrl
   import hsv_pkg::*;
#(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned PIPE_LAT = 3
) (
   input  logic              cmos_pclk,
   input  logic              rst,
   input  logic              enable,
   input  logic              rgb_fram_valid,
   input  logic              rgb_data_valid,
   output logic              conv_en,
   output logic [CoordW-1:0] pix_x,
   output logic [CoordW-1:0] pix_y,
   output logic              hsv_fram_valid,
   output logic              hsv_data_valid,
   output logic              hsv_sof,
   output logic              hsv_eol,
   output logic              hsv_eof,
   output logic              frame_done,
   output logic              frame_err,
   output logic [7:0]        err_cnt,
   output logic              busy
);

   localparam logic [CoordW-1:0] HMax   = CoordW'(H_ACTIVE);
   localparam logic [CoordW-1:0] VMax   = CoordW'(V_ACTIVE);
   localparam logic [CoordW-1:0] HLast  = CoordW'(H_ACTIVE - 1);
   localparam logic [CoordW-1:0] VLast  = CoordW'(V_ACTIVE - 1);
   localparam logic [CoordW:0]   VLines = (CoordW + 1)'(V_ACTIVE);
   localparam logic [3:0]        DrainLast = 4'(PIPE_LAT - 1);

   state_e            state_q, state_d;
   logic              fv_prev_q, dv_prev_q;
   logic [CoordW-1:0] x_q, x_d, y_q, y_d;
   logic              bad_q, bad_d;
   logic [3:0]        drain_q, drain_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [7:0]        err_cnt_q, err_cnt_d;

   logic              fv_rise, dv_fall;
   logic              act, in_geo, in_pix, frame_bad;
   logic [CoordW-1:0] cur_x, cur_y;
   logic              cur_bad;
   logic [CoordW:0]   lines;
   sideband_t         sb_in, sb_out;

   assign fv_rise = rgb_fram_valid & ~fv_prev_q;
   assign dv_fall = dv_prev_q & ~rgb_data_valid;

   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      bad_d     = bad_q;
      drain_d   = drain_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      err_cnt_d = err_cnt_q;
      act       = 1'b0;
      cur_x     = x_q;
      cur_y     = y_q;
      cur_bad   = bad_q;
      in_geo    = 1'b0;
      in_pix    = 1'b0;
      lines     = '0;
      frame_bad = 1'b0;
      sb_in     = '0;

      unique case (state_q)
         StIdle: begin
            if (enable) state_d = StWaitSof;
         end
         StWaitSof: begin
            if (!enable) begin
               state_d = StIdle;
            end else if (fv_rise) begin
               // The SOF edge cycle is already an active cycle, seen with cleared counters.
               act     = 1'b1;
               cur_x   = '0;
               cur_y   = '0;
               cur_bad = 1'b0;
               state_d = StActive;
            end
         end
         StActive: begin
            act = 1'b1;
         end
         StDrain: begin
            if (drain_q == DrainLast) begin
               done_d  = 1'b1;
               drain_d = '0;
               state_d = enable ? StWaitSof : StIdle;
            end else begin
               drain_d = drain_q + 4'd1;
            end
         end
         default: state_d = StIdle;
      endcase

      if (act) begin
         in_geo    = (cur_x < HMax) && (cur_y < VMax);
         in_pix    = rgb_fram_valid & rgb_data_valid & in_geo;
         sb_in.fv  = rgb_fram_valid;
         sb_in.dv  = in_pix;
         sb_in.sof = in_pix & (cur_x == '0) & (cur_y == '0);
         sb_in.eol = in_pix & (cur_x == HLast);
         sb_in.eof = sb_in.eol & (cur_y == VLast);

         x_d   = cur_x;
         y_d   = cur_y;
         bad_d = cur_bad;
         if (rgb_fram_valid & rgb_data_valid & ~in_geo) bad_d = 1'b1;
         if (in_pix) x_d = cur_x + CoordW'(1);
         if (rgb_fram_valid & dv_fall) begin
            x_d = '0;
            y_d = (cur_y == '1) ? cur_y : cur_y + CoordW'(1);
            if (cur_x != HMax) bad_d = 1'b1;
         end

         if (!rgb_fram_valid) begin
            // A trailing partial line still counts toward the line total.
            lines     = {1'b0, cur_y} + {{CoordW{1'b0}}, (cur_x != '0)};
            frame_bad = cur_bad | (lines != VLines) | ((cur_x != '0) & (cur_x != HMax));
            if (frame_bad) begin
               err_d = 1'b1;
               if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            end
            state_d = StDrain;
            drain_d = '0;
         end
      end
   end

   always_ff @(posedge cmos_pclk) begin
      if (rst) begin
         state_q   <= StIdle;
         fv_prev_q <= 1'b0;
         dv_prev_q <= 1'b0;
         x_q       <= '0;
         y_q       <= '0;
         bad_q     <= 1'b0;
         drain_q   <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         fv_prev_q <= rgb_fram_valid;
         dv_prev_q <= rgb_data_valid;
         x_q       <= x_d;
         y_q       <= y_d;
         bad_q     <= bad_d;
         drain_q   <= drain_d;
         done_q    <= done_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   hsv_sideband_delay #(
      .Depth (PIPE_LAT)
   ) u_delay (
      .clk_i (cmos_pclk),
      .clr_i (rst),
      .d_i   (sb_in),
      .q_o   (sb_out)
   );

   assign conv_en        = in_pix;
   assign pix_x          = x_q;
   assign pix_y          = y_q;
   assign hsv_fram_valid = sb_out.fv;
   assign hsv_data_valid = sb_out.dv;
   assign hsv_sof        = sb_out.sof;
   assign hsv_eol        = sb_out.eol;
   assign hsv_eof        = sb_out.eof;
   assign frame_done     = done_q;
   assign frame_err      = err_q;
   assign err_cnt        = err_cnt_q;
   assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_hsv_frame_ctrl.sv
// Bench for hsv_frame_ctrl: directed scenarios plus randomized frames, all checked
// every cycle against a line-list reference model of the sequencer.
module tb_hsv_frame_ctrl;

   localparam int H = 4;
   localparam int V = 2;
   localparam int P = 3;

   bit         clk;
   logic       rst, enable, fv, dv;
   logic       conv_en, hsv_fram_valid, hsv_data_valid, hsv_sof, hsv_eol, hsv_eof;
   logic       frame_done, frame_err, busy;
   logic [9:0] pix_x, pix_y;
   logic [7:0] err_cnt;

   int  tests = 0;
   int  fails = 0;
   bit  chk_on = 0;
   int  conv_cnt = 0;
   int  done_cnt = 0;
   int  errp_cnt = 0;
   bit [2:0] ob[$];

   // Reference model: mode 0 idle, 1 waiting for frame start, 2 in frame, 3 draining.
   int       m_mode;
   bit       m_fvp, m_dvp;
   int       m_x;
   int       m_lens[$];
   bit       m_supp;
   int       m_dcnt;
   bit       m_done, m_err;
   int       m_ecnt;
   bit [4:0] m_pipe[$];

   hsv_frame_ctrl #(
      .H_ACTIVE (H),
      .V_ACTIVE (V),
      .PIPE_LAT (P)
   ) dut (
      .cmos_pclk      (clk),
      .rst            (rst),
      .enable         (enable),
      .rgb_fram_valid (fv),
      .rgb_data_valid (dv),
      .conv_en        (conv_en),
      .pix_x          (pix_x),
      .pix_y          (pix_y),
      .hsv_fram_valid (hsv_fram_valid),
      .hsv_data_valid (hsv_data_valid),
      .hsv_sof        (hsv_sof),
      .hsv_eol        (hsv_eol),
      .hsv_eof        (hsv_eof),
      .frame_done     (frame_done),
      .frame_err      (frame_err),
      .err_cnt        (err_cnt),
      .busy           (busy)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0;
      m_fvp  = 0;
      m_dvp  = 0;
      m_x    = 0;
      m_lens.delete();
      m_supp = 0;
      m_dcnt = 0;
      m_done = 0;
      m_err  = 0;
      m_ecnt = 0;
      m_pipe.delete();
      repeat (P) m_pipe.push_back(5'b0);
   endtask

   always @(negedge clk) begin
      bit rise, fall, enter, act, inpix, sof, eol, eof, bad;
      int n;
      rise  = fv && !m_fvp;
      fall  = m_dvp && !dv;
      enter = (m_mode == 1) && enable && rise;
      act   = (m_mode == 2) || enter;
      if (chk_on) begin
         chk("pix_x", pix_x, m_x);
         chk("pix_y", pix_y, m_lens.size());
         chk("hsv_fram_valid", hsv_fram_valid, m_pipe[0][4]);
         chk("hsv_data_valid", hsv_data_valid, m_pipe[0][3]);
         chk("hsv_sof", hsv_sof, m_pipe[0][2]);
         chk("hsv_eol", hsv_eol, m_pipe[0][1]);
         chk("hsv_eof", hsv_eof, m_pipe[0][0]);
         chk("frame_done", frame_done, m_done);
         chk("frame_err", frame_err, m_err);
         chk("err_cnt", err_cnt, m_ecnt);
         chk("busy", busy, m_mode != 0);
      end
      if (enter) begin
         m_x = 0;
         m_lens.delete();
         m_supp = 0;
      end
      inpix = act && fv && dv && (m_x < H) && (m_lens.size() < V);
      sof   = inpix && m_x == 0 && m_lens.size() == 0;
      eol   = inpix && m_x == H - 1;
      eof   = eol && m_lens.size() == V - 1;
      if (chk_on) begin
         chk("conv_en", conv_en, inpix);
         if (conv_en) conv_cnt++;
         if (frame_done) done_cnt++;
         if (frame_err) errp_cnt++;
         if (hsv_data_valid) ob.push_back({hsv_sof, hsv_eol, hsv_eof});
      end
      if (rst) begin
         model_reset();
      end else begin
         m_pipe.push_back({act && fv, inpix, sof, eol, eof});
         void'(m_pipe.pop_front());
         m_done = 0;
         m_err  = 0;
         case (m_mode)
            0: if (enable) m_mode = 1;
            1: if (!enable) m_mode = 0; else if (rise) m_mode = 2;
            3: begin
               m_dcnt++;
               if (m_dcnt == P) begin
                  m_done = 1;
                  m_mode = enable ? 1 : 0;
               end
            end
            default: ;
         endcase
         if (act) begin
            if (fv && dv && !inpix) m_supp = 1;
            if (inpix) m_x++;
            if (fv && fall) begin
               m_lens.push_back(m_x);
               m_x = 0;
            end
            if (!fv) begin
               n   = m_lens.size() + ((m_x != 0) ? 1 : 0);
               bad = m_supp || (n != V) || (m_x != 0 && m_x != H);
               foreach (m_lens[i]) if (m_lens[i] != H) bad = 1;
               if (bad) begin
                  m_err = 1;
                  if (m_ecnt < 255) m_ecnt++;
               end
               m_mode = 3;
               m_dcnt = 0;
            end
         end
         m_fvp = fv;
         m_dvp = dv;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1; enable = 0; fv = 0; dv = 0;
      repeat (2) tick();
      rst = 0;
      tick();
   endtask

   task automatic run_frame(input int nl, input int l0, input int l1, input int l2,
                            input bit sim_end, input int idle, input bit jitter);
      int len;
      fv = 1; dv = 0;
      tick();
      for (int i = 0; i < nl; i++) begin
         len = (i == 0) ? l0 : (i == 1) ? l1 : l2;
         dv = 1;
         repeat (len) tick();
         dv = 0;
         if (!(sim_end && i == nl - 1)) begin
            if (jitter && $urandom_range(0, 3) == 0) enable = ($urandom_range(0, 3) != 0);
            if (jitter && $urandom_range(0, 39) == 0) rst = 1;
            tick();
            rst = 0;
            repeat ($urandom_range(0, 1)) tick();
         end
      end
      fv = 0; dv = 0;
      repeat (idle) tick();
   endtask

   initial begin
      int c0, d0, e0, n;
      bit [15:0] sof_m, eol_m, eof_m;
      rst = 1; enable = 0; fv = 0; dv = 0;
      model_reset();
      tick();
      chk_on = 1;
      do_reset();
      chk("reset_busy", busy, 0);
      chk("reset_err_cnt", err_cnt, 0);
      chk("reset_hsv_fram_valid", hsv_fram_valid, 0);

      // Nominal 2x4 frame
      enable = 1;
      repeat (2) tick();
      c0 = conv_cnt; e0 = errp_cnt; ob.delete();
      run_frame(2, 4, 4, 0, 0, 0, 0);
      n = 0;
      do begin
         tick();
         n++;
      end while (!frame_done && n < 20);
      chk("nominal_done_latency", n, 4);
      chk("nominal_conv_pulses", conv_cnt - c0, 8);
      chk("nominal_err_pulses", errp_cnt - e0, 0);
      chk("nominal_out_pixels", ob.size(), 8);
      sof_m = '0; eol_m = '0; eof_m = '0;
      foreach (ob[i]) begin
         if (i < 16) begin
            sof_m[i] = ob[i][2];
            eol_m[i] = ob[i][1];
            eof_m[i] = ob[i][0];
         end
      end
      chk("nominal_sof_mask", sof_m, 16'h0001);
      chk("nominal_eol_mask", eol_m, 16'h0088);
      chk("nominal_eof_mask", eof_m, 16'h0080);
      repeat (4) tick();

      // Enable raised mid-frame: that frame is skipped, the next one runs
      do_reset();
      c0 = conv_cnt;
      fv = 1; tick();
      dv = 1; repeat (2) tick();
      enable = 1; repeat (2) tick();
      dv = 0; tick();
      dv = 1; repeat (4) tick();
      dv = 0; tick();
      fv = 0; repeat (6) tick();
      chk("midframe_conv_pulses", conv_cnt - c0, 0);
      c0 = conv_cnt; e0 = errp_cnt;
      run_frame(2, 4, 4, 0, 0, 6, 0);
      chk("next_frame_conv_pulses", conv_cnt - c0, 8);
      chk("next_frame_err_pulses", errp_cnt - e0, 0);

      // Short second line
      do_reset();
      enable = 1; repeat (2) tick();
      e0 = errp_cnt;
      run_frame(2, 4, 3, 0, 0, 6, 0);
      chk("short_err_pulses", errp_cnt - e0, 1);
      chk("short_err_cnt", err_cnt, 1);

      // Overlong first line
      do_reset();
      enable = 1; repeat (2) tick();
      c0 = conv_cnt; e0 = errp_cnt;
      run_frame(2, 6, 4, 0, 0, 6, 0);
      chk("overlong_conv_pulses", conv_cnt - c0, 8);
      chk("overlong_err_pulses", errp_cnt - e0, 1);
      chk("overlong_err_cnt", err_cnt, 1);

      // Reset during pixel 5
      do_reset();
      enable = 1; repeat (2) tick();
      d0 = done_cnt; e0 = errp_cnt;
      fv = 1; dv = 0; tick();
      dv = 1; repeat (4) tick();
      dv = 0; tick();
      dv = 1; tick();
      rst = 1; tick();
      rst = 0;
      chk("rstmid_busy", busy, 0);
      chk("rstmid_hsv_data_valid", hsv_data_valid, 0);
      chk("rstmid_hsv_fram_valid", hsv_fram_valid, 0);
      tick();
      dv = 0; tick();
      dv = 1; repeat (4) tick();
      dv = 0; tick();
      fv = 0; repeat (10) tick();
      chk("rstmid_done_pulses", done_cnt - d0, 0);
      chk("rstmid_err_pulses", errp_cnt - e0, 0);

      // Enable dropped during line 0: frame completes, then idle
      do_reset();
      enable = 1; repeat (2) tick();
      c0 = conv_cnt; d0 = done_cnt;
      fv = 1; tick();
      dv = 1; repeat (2) tick();
      enable = 0; repeat (2) tick();
      dv = 0; tick();
      dv = 1; repeat (4) tick();
      dv = 0; tick();
      fv = 0; repeat (8) tick();
      chk("disable_conv_pulses", conv_cnt - c0, 8);
      chk("disable_done_pulses", done_cnt - d0, 1);
      chk("disable_busy", busy, 0);

      // Error counter saturation
      do_reset();
      enable = 1; repeat (2) tick();
      e0 = errp_cnt;
      repeat (260) run_frame(1, 4, 0, 0, 0, 5, 0);
      chk("sat_err_cnt", err_cnt, 255);
      chk("sat_err_pulses", errp_cnt - e0, 260);

      // Randomized frames, enable changes and resets
      do_reset();
      enable = 1;
      repeat (400) begin
         if ($urandom_range(0, 4) == 0) enable = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 29) == 0) begin
            rst = 1; tick(); rst = 0;
         end
         run_frame($urandom_range(1, 3), $urandom_range(2, 6), $urandom_range(2, 6),
                   $urandom_range(2, 6), 1'($urandom_range(0, 1)), $urandom_range(0, 6), 1);
      end
      repeat (10) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/hsv_frame_ctrl.md
# hsv_frame_ctrl

Frame sequencer for the RGB565-to-HSV pixel converter. Sits between the CMOS capture interface and the converter datapath. It:
- locks onto frame boundaries and counts pixel/line position;
- drives the converter's clock-enable;
- generates sideband markers (valid, SOF, EOL, EOF) delayed to match the converter's pipeline latency;
- checks each frame against the configured geometry.

## Interface
Parameters:
- H_ACTIVE, 640, active pixels per line (2..1023)
- V_ACTIVE, 480, active lines per frame (2..1023)
- PIPE_LAT, 3, converter latency in cycles (1..8)

Ports:
- cmos_pclk  in  1  pixel clock; sole clock
- rst  in  1  reset; synchronous, active-high
- enable  in  1  run request; sampled only at frame boundaries
- rgb_fram_valid  in  1  frame valid from capture
- rgb_data_valid  in  1  pixel valid from capture
- conv_en  out  1  converter clock-enable
- pix_x  out  10  input-side pixel index in line
- pix_y  out  10  input-side line index in frame
- hsv_fram_valid  out  1  frame valid, aligned to converter output
- hsv_data_valid  out  1  pixel valid, aligned to converter output
- hsv_sof  out  1  first pixel of frame, aligned
- hsv_eol  out  1  last pixel of line, aligned
- hsv_eof  out  1  last pixel of frame, aligned
- frame_done  out  1  one-cycle pulse after drain completes
- frame_err  out  1  one-cycle pulse, geometry mismatch at frame end
- err_cnt  out  8  saturating count of frame_err pulses
- busy  out  1  state is not IDLE

## Operation
States: IDLE, WAIT_SOF, ACTIVE, DRAIN.
- **IDLE:** enable=1 goes to WAIT_SOF.
- **WAIT_SOF:** waits for a rising edge of rgb_fram_valid (previous sample 0, current 1), then goes to ACTIVE. The edge cycle itself is an active cycle. Enabling mid-frame therefore skips the remainder of that frame. enable=0 goes back to IDLE.
- **ACTIVE:**
  - in_pix = rgb_fram_valid & rgb_data_valid & (pix_x < H_ACTIVE) & (pix_y < V_ACTIVE).
  - conv_en = in_pix, combinational.
  - Each in_pix increments pix_x.
  - A falling edge of rgb_data_valid while rgb_fram_valid=1 ends the line: pix_x←0, pix_y←pix_y+1, saturating at 1023.
  - Pixels beyond the geometry are suppressed: not forwarded, and conv_en stays 0.
  - rgb_fram_valid=0 goes to DRAIN.
- **DRAIN:** counts PIPE_LAT cycles, then pulses frame_done. Next state is WAIT_SOF if enable=1, else IDLE. Deasserting enable mid-frame never truncates the frame.

Input-side markers, qualified by in_pix:
- sof: x=0 & y=0
- eol: x=H_ACTIVE-1
- eof: eol & y=V_ACTIVE-1

Frame check:
- Evaluated in the cycle ACTIVE exits.
- Error if any of the following holds:
  - line count ≠ V_ACTIVE;
  - any line had pixel count ≠ H_ACTIVE (sticky per-frame flag, set at each line end);
  - data was suppressed.
- On error: frame_err pulses and err_cnt increments, saturating at 255.
- The partial line at frame end counts as a line only if pix_x≠0.

Counters pix_x, pix_y and the per-frame error flag clear on entry to ACTIVE.

## Timing
- Reset values:
  - state IDLE;
  - all outputs 0;
  - pix_x=pix_y=0;
  - err_cnt=0;
  - delay line cleared.
- Sideband alignment: hsv_data_valid, hsv_sof, hsv_eol, hsv_eof are in_pix/sof/eol/eof delayed exactly PIPE_LAT cycles. hsv_fram_valid is (state=ACTIVE & rgb_fram_valid) delayed exactly PIPE_LAT cycles.
- frame_done is asserted PIPE_LAT+1 cycles after the first cycle with rgb_fram_valid=0. This is the cycle after hsv_fram_valid falls.
- rst asserted mid-frame: everything clears at the next edge, including in-flight delay-line contents. No frame_done or frame_err is emitted.
- Simultaneous events:
  - Line end (data_valid falling) in the same cycle as fram_valid falling: the line is counted before the check.
  - A new fram_valid rising edge during DRAIN is ignored; that frame is skipped.

## Structure
- Shared package hsv_pkg:
  - state enum;
  - coordinate width constant (10);
  - sideband struct {fv, dv, sof, eol, eof}.
- One sub-module: hsv_sideband_delay. It is a PIPE_LAT-deep shift register of the sideband struct with synchronous clear, and is reusable wherever converter stages are re-timed.

## Test plan
Benches use H_ACTIVE=4, V_ACTIVE=2, PIPE_LAT=3.
- **Nominal frame:** enable=1, clean frame of 2 lines × 4 pixels.
  - conv_en pulses 8 times;
  - hsv_sof on output pixel 0; hsv_eol on output pixels 3 and 7; hsv_eof on output pixel 7;
  - each output lags its input by 3 cycles;
  - frame_done 4 cycles after fram_valid falls; frame_err=0.
- **Enable mid-frame:** enable rises while fram_valid=1.
  - no conv_en for that frame;
  - the next frame processes fully.
- **Short line:** line 1 has 3 pixels.
  - frame_err pulses once at frame end; err_cnt=1.
- **Overlong line:** line 0 has 6 pixels.
  - pixels 4 and 5 are suppressed (conv_en=0);
  - frame_err=1.
- **Reset mid-frame:** rst during pixel 5.
  - all hsv_* outputs are 0 from the next cycle; state IDLE; no frame_done.
- **Disable and saturation:** enable dropped during line 0.
  - the frame completes, then the controller returns to IDLE (busy=0);
  - separately, 260 bad frames give err_cnt=255.
